bw_product_accumulator: RTL and testbench

//  - Downstream stage of baughwooley8: consumes its signed 16-bit products s[15:0] and

---
 rtl/bw_pkg.sv | 8 +
 rtl/bw_sat_add.sv | 25 ++
 rtl/bw_product_accumulator.sv | 101 ++++++++++
 tb/tb_bw_product_accumulator.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bw_pkg.sv
// rtl/bw_pkg.sv - shared types and widths for the product accumulator
package bw_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} bw_acc_state_t;

  localparam int BW_PROD_W = 16;
  localparam int BW_ACC_W  = 24;
  localparam int BW_CNT_W  = 8;
endpackage

// File: rtl/bw_sat_add.sv
// rtl/bw_sat_add.sv - signed accumulator + product add with saturate or wrap
module bw_sat_add #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  input  logic              sat_en,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);
  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_wide;

  // One guard bit is enough: a single add can leave range by at most one step.
  assign w_wide = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b};
  assign ovf    = w_wide[ACC_W] ^ w_wide[ACC_W-1];

  always_comb begin
    sum = w_wide[ACC_W-1:0];
    if (ovf && sat_en) sum = w_wide[ACC_W] ? MIN_V : MAX_V;
  end
endmodule

// File: rtl/bw_product_accumulator.sv
// rtl/bw_product_accumulator.sv - accumulates a run of signed products into one result
module bw_product_accumulator
  import bw_pkg::*;
#(
  parameter int PROD_W = BW_PROD_W,
  parameter int ACC_W  = BW_ACC_W,
  parameter int CNT_W  = BW_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              sat_en,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              busy
);
  bw_acc_state_t r_state, w_next;

  logic [CNT_W-1:0] r_len, r_count;
  logic             r_sat, r_ovf, r_ovf_out;
  logic [ACC_W-1:0] r_acc, r_acc_out;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf, w_ovf_run, w_xfer, w_last;

  bw_sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
    .a      (r_acc),
    .b      (prod),
    .sat_en (r_sat),
    .sum    (w_sum),
    .ovf    (w_add_ovf)
  );

  assign prod_ready = (r_state == ACCUM);
  assign acc_valid  = (r_state == HOLD);
  assign busy       = (r_state != IDLE);
  assign acc_out    = r_acc_out;
  assign overflow   = r_ovf_out;
  assign w_xfer     = prod_valid && prod_ready;
  assign w_last     = (r_count + CNT_W'(1)) == r_len;
  assign w_ovf_run  = r_ovf | w_add_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (len == '0) ? HOLD : ACCUM;
      ACCUM:   if (w_xfer && w_last) w_next = HOLD;
      HOLD:    if (acc_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_count   <= '0;
      r_sat     <= 1'b0;
      r_ovf     <= 1'b0;
      r_acc     <= '0;
      r_acc_out <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_len     <= len;
          r_sat     <= sat_en;
          r_acc     <= '0;
          r_ovf     <= 1'b0;
          r_count   <= '0;
          r_acc_out <= '0;
          r_ovf_out <= 1'b0;
        end
        ACCUM: if (w_xfer) begin
          r_acc   <= w_sum;
          r_ovf   <= w_ovf_run;
          r_count <= r_count + CNT_W'(1);
          // Result registers load only on the final product so they read 0 mid-run.
          if (w_last) begin
            r_acc_out <= w_sum;
            r_ovf_out <= w_ovf_run;
          end
        end
        HOLD: if (acc_ready) begin
          r_acc_out <= '0;
          r_ovf_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bw_product_accumulator.sv
// tb/tb_bw_product_accumulator.sv - self-checking bench for bw_product_accumulator
module tb_bw_product_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        sat_en = 1'b0;
  logic        prod_valid = 1'b0;
  logic [15:0] prod = '0;
  logic        acc_ready = 1'b0;

  logic        prod_ready_a, acc_valid_a, overflow_a, busy_a;
  logic [23:0] acc_out_a;
  logic        prod_ready_b, acc_valid_b, overflow_b, busy_b;
  logic [19:0] acc_out_b;

  int checks = 0;
  int errors = 0;

  logic [23:0] cap_a;
  logic [19:0] cap_b;
  logic        cap_ov_a, cap_ov_b;

  always #5 clk = ~clk;

  bw_product_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .sat_en(sat_en),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready_a),
    .acc_valid(acc_valid_a), .acc_ready(acc_ready), .acc_out(acc_out_a),
    .overflow(overflow_a), .busy(busy_a)
  );

  bw_product_accumulator #(.PROD_W(16), .ACC_W(20), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .sat_en(sat_en),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready_b),
    .acc_valid(acc_valid_b), .acc_ready(acc_ready), .acc_out(acc_out_b),
    .overflow(overflow_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer running sum, clamped or wrapped into accw-bit signed range.
  function automatic void model(input int q[$], input bit sat, input int accw,
                                output logic [63:0] res, output bit ovf);
    longint maxv, minv, acc, s;
    maxv = (longint'(1) <<< (accw - 1)) - 1;
    minv = -maxv - 1;
    acc  = 0;
    ovf  = 1'b0;
    foreach (q[i]) begin
      s = acc + longint'(q[i]);
      if (s > maxv || s < minv) begin
        ovf = 1'b1;
        if (sat) s = (s > maxv) ? maxv : minv;
        else     s = (s > maxv) ? s - (longint'(1) <<< accw) : s + (longint'(1) <<< accw);
      end
      acc = s;
    end
    res = 64'(acc) & ((64'd1 << accw) - 64'd1);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},   {62'd0, busy_a, busy_b}, 64'd0);
    chk({tag, "_valid"},  {62'd0, acc_valid_a, acc_valid_b}, 64'd0);
    chk({tag, "_pready"}, {62'd0, prod_ready_a, prod_ready_b}, 64'd0);
    chk({tag, "_acc"},    {20'd0, acc_out_a, acc_out_b}, 64'd0);
    chk({tag, "_ovf"},    {62'd0, overflow_a, overflow_b}, 64'd0);
  endtask

  // Drives one complete run on both instances and checks timing and the result.
  task automatic do_run(input string tag, input int q[$], input bit sat,
                        input int max_gap, input int hold_cycles, input bit poke_start);
    logic [63:0] exp_a, exp_b;
    bit          eo_a, eo_b;
    int          gap;
    model(q, sat, 24, exp_a, eo_a);
    model(q, sat, 20, exp_b, eo_b);
    @(negedge clk);
    start = 1'b1; len = 8'(q.size()); sat_en = sat;
    @(negedge clk);
    start = 1'b0; sat_en = ~sat;
    chk({tag, "_busy_after_start"}, {63'd0, busy_a}, 64'd1);
    foreach (q[i]) begin
      gap = $urandom_range(max_gap, 0);
      for (int g = 0; g < gap; g++) begin
        chk({tag, "_pready_gap"}, {62'd0, prod_ready_a, prod_ready_b}, 64'd3);
        @(negedge clk);
      end
      chk({tag, "_pready"}, {62'd0, prod_ready_a, prod_ready_b}, 64'd3);
      chk({tag, "_novalid_mid"}, {63'd0, acc_valid_a}, 64'd0);
      prod_valid = 1'b1; prod = 16'(q[i]);
      @(negedge clk);
      prod_valid = 1'b0; prod = 16'($urandom);
    end
    chk({tag, "_valid_lat"}, {62'd0, acc_valid_a, acc_valid_b}, 64'd3);
    chk({tag, "_pready_hold"}, {62'd0, prod_ready_a, prod_ready_b}, 64'd0);
    chk({tag, "_acc_a"}, {40'd0, acc_out_a}, exp_a);
    chk({tag, "_acc_b"}, {44'd0, acc_out_b}, exp_b);
    chk({tag, "_ovf_a"}, {63'd0, overflow_a}, {63'd0, eo_a});
    chk({tag, "_ovf_b"}, {63'd0, overflow_b}, {63'd0, eo_b});
    cap_a = acc_out_a; cap_b = acc_out_b; cap_ov_a = overflow_a; cap_ov_b = overflow_b;
    for (int h = 0; h < hold_cycles; h++) begin
      if (poke_start && h == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_hold_valid"}, {62'd0, acc_valid_a, acc_valid_b}, 64'd3);
      chk({tag, "_hold_stable"}, {20'd0, acc_out_a, acc_out_b}, {20'd0, exp_a[23:0], exp_b[19:0]});
    end
    acc_ready = 1'b1;
    if (poke_start) start = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0; start = 1'b0;
    check_idle({tag, "_after_hs"});
    @(negedge clk);
    check_idle({tag, "_idle2"});
  endtask

  initial begin
    int q[$];
    int n;
    bit s;

    #2;
    check_idle("reset");
    @(negedge clk);
    check_idle("reset_clk");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("released");

    // Run 1: -25*35 = -875 four times back to back.
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(-25 * 35);
    do_run("t1", q, 1'b0, 0, 0, 1'b0);
    chk("t1_lit", {40'd0, cap_a}, 64'hFFF254);

    // Run 2: gaps between products.
    q = {100, -300, 50};
    do_run("t2", q, 1'b1, 2, 0, 1'b0);
    chk("t2_lit", {40'd0, cap_a}, 64'hFFFF6A);

    // Run 3: 17 x -32768 overflows the 20-bit instance in both modes.
    q = {};
    for (int i = 0; i < 17; i++) q.push_back(-32768);
    do_run("t3s", q, 1'b1, 0, 0, 1'b0);
    chk("t3s_lit", {44'd0, cap_b}, 64'h80000);
    chk("t3s_ovf", {63'd0, cap_ov_b}, 64'd1);
    do_run("t3w", q, 1'b0, 1, 0, 1'b0);
    chk("t3w_lit", {44'd0, cap_b}, 64'h78000);
    chk("t3w_ovf", {63'd0, cap_ov_b}, 64'd1);

    // Run 4: empty run goes straight to HOLD.
    q = {};
    do_run("t4", q, 1'b0, 0, 0, 1'b0);

    // Run 5: backpressure and start pokes during HOLD.
    q = {1234, -5678, 32767};
    do_run("t5", q, 1'b1, 1, 5, 1'b1);

    // Run 6: asynchronous reset after two of four products.
    @(negedge clk);
    start = 1'b1; len = 8'd4; sat_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1; prod = 16'h7000;
      @(negedge clk);
    end
    prod_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("t6_released");
    q = {-7, 9, -11, 13};
    do_run("t6_fresh", q, 1'b0, 0, 0, 1'b0);

    // Randomized runs, some biased toward large products to hit overflow.
    for (int r = 0; r < 14; r++) begin
      q = {};
      n = (r % 3 == 0) ? int'($urandom_range(40, 15)) : int'($urandom_range(12, 1));
      s = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        if (r % 3 == 0) q.push_back(($urandom_range(1, 0) == 1) ? int'($urandom_range(32767, 20000))
                                                               : -int'($urandom_range(32768, 20000)));
        else            q.push_back(int'($urandom_range(65535, 0)) - 32768);
      end
      do_run("rnd", q, s, 2, int'($urandom_range(3, 0)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
